// File: rtl/xnor_cmp_scheduler.sv
// Round-robin scheduler that time-shares one external XNOR cell among NREQ requesters.
// Each grant runs a W-bit equality compare bit-serially, LSB first, through the cell.
module xnor_cmp_scheduler #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       a_in,
    input  logic [NREQ*W-1:0]       b_in,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic                    eq,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic                    cell_a,
    output logic                    cell_b,
    input  logic                    cell_y
);

    localparam int unsigned IdW  = $clog2(NREQ);
    // One extra bit so the counter never wraps, even when W is a power of two.
    localparam int unsigned CntW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [IdW-1:0]  pick_q, pick_d;
    logic [IdW-1:0]  done_id_q, done_id_d;
    logic [W-1:0]    sh_a_q, sh_a_d;
    logic [W-1:0]    sh_b_q, sh_b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            eq_q, eq_d;
    logic            done_q, done_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic            arb_found;
    logic [IdW-1:0]  arb_pick;

    // Round-robin search from ptr upward with wrap; walking downward lets the
    // lowest offset from ptr overwrite the others, so no early break is needed.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req[(int'(ptr_q) + i) % int'(NREQ)]) begin
                arb_found = 1'b1;
                arb_pick  = IdW'((int'(ptr_q) + i) % int'(NREQ));
            end
        end
    end

    // Next-state logic: grant/capture in IDLE, serial compare in RUN, one-cycle DONE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        pick_d    = pick_q;
        done_id_d = done_id_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        eq_d      = eq_q;
        done_d    = 1'b0;
        gnt_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (arb_found) begin
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << arb_pick;
                    pick_d  = arb_pick;
                    sh_a_d  = a_in[arb_pick*W +: W];
                    sh_b_d  = b_in[arb_pick*W +: W];
                    cnt_d   = '0;
                    acc_d   = 1'b1;
                    ptr_d   = IdW'((int'(arb_pick) + 1) % int'(NREQ));
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d  = acc_q & cell_y;
                sh_a_d = sh_a_q >> 1;
                sh_b_d = sh_b_q >> 1;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == CntW'(W - 1)) begin
                    eq_d      = acc_q & cell_y;
                    done_id_d = pick_q;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            pick_q    <= '0;
            done_id_q <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            eq_q      <= 1'b0;
            done_q    <= 1'b0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            pick_q    <= pick_d;
            done_id_q <= done_id_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            eq_q      <= eq_d;
            done_q    <= done_d;
            gnt_q     <= gnt_d;
        end
    end

    // Cell inputs come straight from the shift-register LSBs.
    assign cell_a  = sh_a_q[0];
    assign cell_b  = sh_b_q[0];
    assign gnt     = gnt_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign eq      = eq_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_xnor_cmp_scheduler.sv
// Self-checking bench: randomized and directed stimulus against a timestamp-based model.
module tb_xnor_cmp_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IdW  = $clog2(NREQ);

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   a_in;
    logic [NREQ*W-1:0]   b_in;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                done;
    logic                eq;
    logic [IdW-1:0]      done_id;
    logic                cell_a;
    logic                cell_b;
    logic                cell_y;

    // Stand-in for the external gate-level XNOR cell.
    assign cell_y = ~(cell_a ^ cell_b);

    xnor_cmp_scheduler #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .eq      (eq),
        .done_id (done_id),
        .cell_a  (cell_a),
        .cell_b  (cell_b),
        .cell_y  (cell_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Model: a compare granted in cycle g is busy for cycles g..g+W, done in g+W,
    // and presents operand bit k to the cell in cycle g+k.
    bit         model_on = 0;
    int         g_cyc    = -1;
    int         ptr      = 0;
    int         cur_id   = 0;
    logic [W-1:0] cur_a, cur_b;
    logic       last_eq  = 0;
    int         last_id  = 0;
    int         n_grants = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model across the edge.
    task automatic tick();
        bit active;
        bit in_run;
        bit found;
        int idx;
        @(negedge clk);
        active = (g_cyc >= 0) && (cyc >= g_cyc) && (cyc <= g_cyc + W);
        in_run = active && (cyc < g_cyc + W);
        if (model_on) begin
            if (active && cyc == g_cyc + W) begin
                last_eq = (cur_a == cur_b);
                last_id = cur_id;
            end
            chk("gnt", 32'(gnt), (active && cyc == g_cyc) ? (32'd1 << cur_id) : 32'd0);
            chk("busy", 32'(busy), 32'(active));
            chk("done", 32'(done), 32'(active && cyc == g_cyc + W));
            chk("eq", 32'(eq), 32'(last_eq));
            chk("done_id", 32'(done_id), 32'(last_id));
            chk("cell_a", 32'(cell_a), in_run ? 32'(cur_a[cyc - g_cyc]) : 32'd0);
            chk("cell_b", 32'(cell_b), in_run ? 32'(cur_b[cyc - g_cyc]) : 32'd0);
        end
        if (!rst_n) begin
            model_on = 1;
            g_cyc    = -1;
            ptr      = 0;
            last_eq  = 0;
            last_id  = 0;
        end else if (model_on && !active && req != '0) begin
            found = 0;
            for (int i = 0; i < NREQ; i++) begin
                idx = (ptr + i) % NREQ;
                if (!found && req[idx]) begin
                    found  = 1;
                    cur_id = idx;
                end
            end
            cur_a    = a_in[cur_id*W +: W];
            cur_b    = b_in[cur_id*W +: W];
            g_cyc    = cyc + 1;
            ptr      = (cur_id + 1) % NREQ;
            n_grants++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [W-1:0] ra;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);

        // Equal operands on requester 0.
        set_op(0, 8'hA5, 8'hA5);
        req = 4'b0001;
        tick();
        req = '0;
        ticks(12);

        // MSB differs, then LSB differs.
        set_op(0, 8'hA5, 8'h25);
        req = 4'b0001;
        tick();
        req = '0;
        ticks(12);
        set_op(0, 8'h01, 8'h00);
        req = 4'b0001;
        tick();
        req = '0;
        ticks(12);

        // All requesting: round-robin order, one grant every W+2 cycles.
        for (int i = 0; i < NREQ; i++) set_op(i, W'($urandom), W'($urandom));
        set_op(2, 8'h3C, 8'h3C);
        req = 4'b1111;
        ticks(52);
        req = '0;
        ticks(12);
        chk("grant_count", 32'(n_grants), 32'd9);

        // req1 arrives while busy; operands scrambled during RUN.
        set_op(0, 8'h77, 8'h77);
        req = 4'b0001;
        tick();
        req = 4'b0010;
        set_op(1, 8'h5A, 8'h5A);
        for (int i = 0; i < 24; i++) begin
            if (i < W) a_in[0 +: W] = W'($urandom);
            tick();
        end
        req = '0;
        ticks(4);

        // Reset in the third RUN cycle, then a fresh compare.
        set_op(0, 8'hC3, 8'hC3);
        req = 4'b0001;
        tick();
        req = '0;
        ticks(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ticks(3);
        ra = W'($urandom);
        set_op(0, ra, ra);
        req = 4'b0001;
        tick();
        req = '0;
        ticks(12);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) req = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                ra = W'($urandom);
                case ($urandom_range(0, 2))
                    0: set_op(i, ra, ra);
                    1: set_op(i, ra, ra ^ (W'(1) << $urandom_range(0, W - 1)));
                    default: set_op(i, ra, W'($urandom));
                endcase
            end
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1'b1;
        req   = '0;
        ticks(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
